// File: rtl/battle_front_sched_pkg.sv
// Shared definitions for the BattleFront scheduler: FSM states, source IDs
// and the default geometry/timeout used by the top-level parameters.
package battle_front_sched_pkg;

  // Default battlefield location width.
  localparam int LOC_W_DEF = 9;

  // Default number of WAIT cycles before a run is aborted.
  localparam int TIMEOUT_CYC_DEF = 64;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  // Source IDs. The one-hot select from the arbiter uses the same bit
  // positions: bit 0 tick, bit 1 client 0, bit 2 client 1.
  typedef enum logic [1:0] {
    SRC_TICK = 2'd0,
    SRC_C0   = 2'd1,
    SRC_C1   = 2'd2
  } src_t;

  // Convert a one-hot arbiter select into a source ID.
  function automatic src_t selToSrc(input logic [2:0] sel);
    src_t src;
    if (sel[2]) begin
      src = SRC_C1;
    end else if (sel[1]) begin
      src = SRC_C0;
    end else begin
      src = SRC_TICK;
    end
    return src;
  endfunction

endpackage

// File: rtl/battle_front_sched_arb.sv
// Two-client round-robin arbiter with tick override. Produces a one-hot
// source select every cycle and advances its pointer when a run reports.
module front_sched_arb
  import battle_front_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tickReq,
  input  logic       req0,
  input  logic       req1,
  input  logic       update,
  input  logic [1:0] updateSrc,
  output logic [2:0] sel
);

  // 0: client 0 wins a tie, 1: client 1 wins a tie.
  logic rrPtr;

  // Select: tick beats both clients, then round-robin between clients.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    sel = 3'b000;
    if (tickReq) begin
      sel = 3'b001;
    end else if (req0 && (!req1 || !rrPtr)) begin
      sel = 3'b010;
    end else if (req1) begin
      sel = 3'b100;
    end
  end

  // Pointer update: the client just served loses the next tie.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      rrPtr <= 1'b0;
    end else if (update) begin
      if (updateSrc == SRC_C0) begin
        rrPtr <= 1'b1;
      end else if (updateSrc == SRC_C1) begin
        rrPtr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/battle_front_sched.sv
// BattleFront scheduler: serves a periodic tick refresh and two clients,
// one BattleFront run at a time, and reports captured fronts and errors.
module battle_front_sched
  import battle_front_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int LOC_W       = LOC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             req0,
  input  logic             req1,
  input  logic             bf_done,
  input  logic [LOC_W-1:0] bf_friendly_front,
  input  logic [LOC_W-1:0] bf_enemy_front,
  output logic             bf_start,
  output logic             bf_ack,
  output logic             gnt_tick,
  output logic             gnt0,
  output logic             gnt1,
  output logic [LOC_W-1:0] friendly_front,
  output logic [LOC_W-1:0] enemy_front,
  output logic             busy,
  output logic             timeout_err,
  output logic             tick_overrun
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  state_t           stateNext;
  src_t             servedSrc;
  logic             tickPend;
  logic [CNT_W-1:0] waitCnt;
  logic [2:0]       sel;
  logic             tickReq;
  logic             reqLive0;
  logic             reqLive1;
  logic             reporting;
  logic             waitExit;

  // A tick arriving this cycle is already a pending refresh for IDLE.
  assign tickReq = tickPend | tick;

  // The grant pulse is registered out of REPORT, so during that pulse the
  // client still holds its old request; mask it so it is not served twice.
  assign reqLive0 = req0 & ~gnt0;
  assign reqLive1 = req1 & ~gnt1;

  assign reporting = (state == ST_REPORT);
  assign waitExit  = bf_done || (waitCnt == CNT_LAST);

  front_sched_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .tickReq   (tickReq),
    .req0      (reqLive0),
    .req1      (reqLive1),
    .update    (reporting),
    .updateSrc (servedSrc),
    .sel       (sel)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and the Moore pulses to BattleFront.
  always_comb begin
    stateNext = state;
    bf_start  = 1'b0;
    bf_ack    = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (|sel) begin
          stateNext = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        bf_start  = 1'b1;
        stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        if (waitExit) begin
          stateNext = ST_ACK;
        end
      end
      ST_ACK: begin
        bf_ack    = 1'b1;
        stateNext = ST_REPORT;
      end
      ST_REPORT: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Run datapath: served source, WAIT counter, fronts, timeout and grants.
  always_ff @(posedge clk) begin
    if (!rst) begin
      servedSrc      <= SRC_TICK;
      waitCnt        <= '0;
      friendly_front <= '0;
      enemy_front    <= '0;
      timeout_err    <= 1'b0;
      gnt_tick       <= 1'b0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
    end else begin
      gnt_tick <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|sel) begin
            servedSrc <= selToSrc(sel);
          end
        end
        ST_LAUNCH: begin
          waitCnt <= '0;
        end
        ST_WAIT: begin
          // Done on the limit cycle still counts as a successful capture.
          if (bf_done) begin
            friendly_front <= bf_friendly_front;
            enemy_front    <= bf_enemy_front;
          end else if (waitCnt == CNT_LAST) begin
            timeout_err <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        ST_REPORT: begin
          case (servedSrc)
            SRC_TICK: gnt_tick <= 1'b1;
            SRC_C0:   gnt0     <= 1'b1;
            SRC_C1:   gnt1     <= 1'b1;
            default:  gnt_tick <= 1'b0;
          endcase
        end
        default: begin
          waitCnt <= waitCnt;
        end
      endcase
    end
  end

  // Tick bookkeeping: a new tick always wins over the REPORT clear, and a
  // tick on top of an unserved one flags an overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tickPend     <= 1'b0;
      tick_overrun <= 1'b0;
    end else if (tick) begin
      tickPend <= 1'b1;
      if (tickPend) begin
        tick_overrun <= 1'b1;
      end
    end else if (reporting && (servedSrc == SRC_TICK)) begin
      tickPend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_battle_front_sched.sv
// Self-checking bench for battle_front_sched: a table of single runs plus
// hand-written overrun and mid-run reset sequences.
module tb_battle_front_sched;

  localparam int TO_CYC = 8;
  localparam int LW     = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic          bf_done = 1'b0;
  logic [LW-1:0] bf_friendly_front = '0;
  logic [LW-1:0] bf_enemy_front = '0;
  logic          bf_start, bf_ack, gnt_tick, gnt0, gnt1, busy;
  logic          timeout_err, tick_overrun;
  logic [LW-1:0] friendly_front, enemy_front;

  battle_front_sched #(.TIMEOUT_CYC(TO_CYC), .LOC_W(LW)) dut (
    .clk               (clk),
    .rst               (rst),
    .tick              (tick),
    .req0              (req0),
    .req1              (req1),
    .bf_done           (bf_done),
    .bf_friendly_front (bf_friendly_front),
    .bf_enemy_front    (bf_enemy_front),
    .bf_start          (bf_start),
    .bf_ack            (bf_ack),
    .gnt_tick          (gnt_tick),
    .gnt0              (gnt0),
    .gnt1              (gnt1),
    .friendly_front    (friendly_front),
    .enemy_front       (enemy_front),
    .busy              (busy),
    .timeout_err       (timeout_err),
    .tick_overrun      (tick_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          tick;
    logic          r0;
    logic          r1;
    int            dly;     // WAIT cycle on which bf_done is raised, 0 = never
    logic [LW-1:0] ff;
    logic [LW-1:0] ef;
    logic [2:0]    expG;    // {gnt1, gnt0, gnt_tick}
    logic [LW-1:0] expFF;
    logic [LW-1:0] expEF;
    logic          expTo;
    logic          expOv;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Event counters, updated just after each rising edge.
  int         cyc = 0;
  int         cntStart = 0, cntAck = 0, cntGnt = 0;
  int         lastStartCyc = 0, lastGntCyc = 0;
  logic [2:0] lastGnt = '0;
  int         snapStart = 0, snapAck = 0, snapGnt = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bf_start) begin
      cntStart++;
      lastStartCyc = cyc;
    end
    if (bf_ack) cntAck++;
    if (gnt_tick | gnt0 | gnt1) begin
      cntGnt++;
      lastGnt    = {gnt1, gnt0, gnt_tick};
      lastGntCyc = cyc;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic takeSnap();
    snapStart = cntStart;
    snapAck   = cntAck;
    snapGnt   = cntGnt;
  endtask

  task automatic waitStart(input string nm);
    int guard = 0;
    while (cntStart == snapStart && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({nm, " start seen"}, 32'(cntStart != snapStart), 32'd1);
  endtask

  task automatic waitGnt(input string nm);
    int guard = 0;
    while (cntGnt == snapGnt && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check({nm, " gnt seen"}, 32'(cntGnt != snapGnt), 32'd1);
  endtask

  // Raise bf_done for one cycle on WAIT cycle dly of the current run.
  task automatic driveDone(input int dly, input logic [LW-1:0] ff, input logic [LW-1:0] ef);
    while (cyc < lastStartCyc + dly) @(negedge clk);
    bf_done           = 1'b1;
    bf_friendly_front = ff;
    bf_enemy_front    = ef;
    @(negedge clk);
    bf_done           = 1'b0;
    bf_friendly_front = '0;
    bf_enemy_front    = '0;
  endtask

  task automatic dropServed();
    if (lastGnt[1]) req0 = 1'b0;
    if (lastGnt[2]) req1 = 1'b0;
  endtask

  task automatic runVec(input vec_t v, input string nm);
    int d;
    d = (v.dly > 0) ? v.dly : TO_CYC;
    @(negedge clk);
    tick = v.tick;
    req0 = v.r0;
    req1 = v.r1;
    @(negedge clk);
    tick = 1'b0;
    waitStart(nm);
    if (v.dly > 0) driveDone(v.dly, v.ff, v.ef);
    waitGnt(nm);
    dropServed();
    check({nm, " gnt"}, 32'(lastGnt), 32'(v.expG));
    check({nm, " latency"}, 32'(lastGntCyc - lastStartCyc), 32'(d + 3));
    check({nm, " starts"}, 32'(cntStart - snapStart), 32'd1);
    check({nm, " acks"}, 32'(cntAck - snapAck), 32'd1);
    check({nm, " friendly"}, 32'(friendly_front), 32'(v.expFF));
    check({nm, " enemy"}, 32'(enemy_front), 32'(v.expEF));
    check({nm, " timeout_err"}, 32'(timeout_err), 32'(v.expTo));
    check({nm, " tick_overrun"}, 32'(tick_overrun), 32'(v.expOv));
    takeSnap();
  endtask

  task automatic checkAllZero(input string nm);
    check({nm, " busy"}, 32'(busy), 32'd0);
    check({nm, " bf_start"}, 32'(bf_start), 32'd0);
    check({nm, " bf_ack"}, 32'(bf_ack), 32'd0);
    check({nm, " gnts"}, 32'({gnt1, gnt0, gnt_tick}), 32'd0);
    check({nm, " friendly"}, 32'(friendly_front), 32'd0);
    check({nm, " enemy"}, 32'(enemy_front), 32'd0);
    check({nm, " timeout_err"}, 32'(timeout_err), 32'd0);
    check({nm, " tick_overrun"}, 32'(tick_overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    vec_t v;
    int   startsBefore;

    //             tick r0    r1    dly ff      ef      expG    expFF   expEF   to    ov
    vecs[0] = '{1'b0, 1'b1, 1'b1, 2, 9'd1,   9'd2,   3'b010, 9'd1,   9'd2,   1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 3, 9'd3,   9'd4,   3'b100, 9'd3,   9'd4,   1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1, 9'd5,   9'd6,   3'b010, 9'd5,   9'd6,   1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8, 9'd7,   9'd8,   3'b100, 9'd7,   9'd8,   1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5, 9'd474, 9'd39,  3'b001, 9'd474, 9'd39,  1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 3, 9'd58,  9'd487, 3'b001, 9'd58,  9'd487, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 0, 9'd9,   9'd9,   3'b010, 9'd58,  9'd487, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 2, 9'd11,  9'd12,  3'b100, 9'd11,  9'd12,  1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1, 9'd13,  9'd14,  3'b010, 9'd13,  9'd14,  1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 2, 9'd100, 9'd200, 3'b010, 9'd100, 9'd200, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;
    takeSnap();

    // Round-robin, done-on-limit boundary, tick priority and timeout.
    for (int i = 0; i < 9; i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Two ticks during a client run: one overrun, exactly one extra tick run.
    @(negedge clk);
    req0 = 1'b1;
    waitStart("ovr c0");
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    driveDone(6, 9'd21, 9'd22);
    waitGnt("ovr c0");
    dropServed();
    check("ovr c0 gnt", 32'(lastGnt), 32'b010);
    check("ovr flag", 32'(tick_overrun), 32'd1);
    takeSnap();
    waitStart("ovr tick");
    driveDone(2, 9'd23, 9'd24);
    waitGnt("ovr tick");
    check("ovr tick gnt", 32'(lastGnt), 32'b001);
    check("ovr tick friendly", 32'(friendly_front), 32'd23);
    takeSnap();
    startsBefore = cntStart;
    repeat (15) @(negedge clk);
    check("ovr no extra run", 32'(cntStart - startsBefore), 32'd0);
    check("ovr idle busy", 32'(busy), 32'd0);

    // Reset in the middle of WAIT abandons the run.
    req0 = 1'b1;
    waitStart("rst run");
    while (cyc < lastStartCyc + 2) @(negedge clk);
    check("rst run busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("midrst");
    repeat (3) @(negedge clk);
    check("midrst no ack", 32'(cntAck - snapAck), 32'd0);
    check("midrst no gnt", 32'(cntGnt - snapGnt), 32'd0);
    takeSnap();
    rst = 1'b1;
    v = vecs[9];
    runVec(v, "postrst");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/battle_front_sched.md
BATTLE_FRONT_SCHED -- requirements
Module: battle_front_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: max cycles spent in WAIT before abort.
REQ-002 Parameter LOC_W, default 9: battlefield location width.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 tick  input  1  one-cycle frame pulse requesting a periodic front refresh.
REQ-006 req0, req1  input  1 each  level requests from client 0/1, held until matching gnt.
REQ-007 bf_done  input  1  BattleFront Done.
REQ-008 bf_friendly_front, bf_enemy_front  input  LOC_W each  BattleFront results.
REQ-009 bf_start, bf_ack  output  1 each  one-cycle Start/Ack pulses to BattleFront.
REQ-010 gnt_tick, gnt0, gnt1  output  1 each  one-cycle completion pulse to the served source.
REQ-011 friendly_front, enemy_front  output  LOC_W each  last successfully captured fronts.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 timeout_err, tick_overrun  output  1 each  sticky error flags.

Function
REQ-014 States IDLE, LAUNCH, WAIT, ACK, REPORT; exactly one run in flight at a time.
REQ-015 tick sets tick_pend on any cycle in any state; tick while tick_pend already set sets tick_overrun.
REQ-016 IDLE: if tick_pend, req0 or req1 is set, record the served source and go to LAUNCH next cycle; otherwise stay.
REQ-017 Priority: tick_pend over clients; between req0/req1, round-robin, with client 0 first after reset and the last-served client losing ties.
REQ-018 LAUNCH: bf_start=1 for exactly one cycle, clear WAIT counter, then WAIT.
REQ-019 WAIT: when bf_done=1, register both bf fronts into friendly_front/enemy_front, then ACK.
REQ-020 WAIT: when the counter reaches TIMEOUT_CYC-1 without bf_done, set timeout_err, leave the fronts unchanged, then ACK.
REQ-021 bf_done in the same cycle as the timeout limit counts as done; timeout_err is not set.
REQ-022 bf_done outside WAIT is ignored.
REQ-023 ACK: bf_ack=1 for exactly one cycle, then REPORT.
REQ-024 REPORT: pulse the gnt of the served source for one cycle, clear tick_pend if tick was served, then IDLE.
REQ-025 A gnt is issued on timeout too; clients detect failure via timeout_err.
REQ-026 Latency: a request seen in IDLE at cycle N gives bf_start at N+1 and gnt at N+D+4, where D is the number of WAIT cycles (D>=1).
REQ-027 req0/req1 dropped before grant are not served; a req still high after its gnt is treated as a new request.
REQ-028 The fronts change only in WAIT on bf_done and are stable otherwise.

Reset
REQ-029 When rst=0 at a clock edge: state=IDLE; all outputs 0, including fronts, gnt, bf_start, bf_ack, busy, timeout_err and tick_overrun; tick_pend, counter and round-robin pointer also 0.
REQ-030 Reset mid-run abandons the run without bf_ack or gnt; the first run after reset re-issues bf_start.

Structure
REQ-031 Shared package holds: state enum, LOC_W, TIMEOUT_CYC default, source-ID encoding (TICK/C0/C1).
REQ-032 One sub-module, front_sched_arb: two-client round-robin with tick override, returning a one-hot source select and updating its pointer on REPORT.

Verification
REQ-033 Single tick, bf_done 5 cycles after bf_start with fronts 474/39 -> bf_start at +1, one bf_ack, gnt_tick once, friendly_front=474, enemy_front=39.
REQ-034 req0 and req1 held together from reset, each run completing normally -> grants in order gnt0, gnt1, gnt0; exactly one bf_start per grant.
REQ-035 tick plus req0 asserted together -> tick served first (fronts 58/487), then req0; no overrun.
REQ-036 bf_done never asserted, TIMEOUT_CYC=8 -> timeout_err=1 after 8 WAIT cycles, bf_ack then gnt pulse, fronts keep their prior values 58/487.
REQ-037 Two ticks during one run -> tick_overrun=1; only one extra tick run follows.
REQ-038 rst=0 asserted during WAIT -> next cycle all outputs 0 and IDLE, no bf_ack; a later req0 completes normally.
